i2c_rx_byte: RTL

Receive byte assembler for the I2C controller, placed directly downstream of the bit-level reader. It takes the reader's per-bit load strobe, sampled data bit and start/stop flags, and shifts the bits MSB-first into bytes. It tags the first byte after a START as the address byte and matches it against the own slave address. Completed bytes go to a small FIFO with a valid/ready handshake toward the protocol FSM or host.

---
 rtl/i2c_rx_byte.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/i2c_rx_byte.sv
// i2c_rx_byte
// Receive byte assembler placed after the I2C bit-level reader. Qualified bit
// strobes are shifted MSB-first into bytes. The first byte after a START is
// tagged and compared against the own slave address. Completed bytes are
// queued in a small FIFO with a valid/ready handshake toward the consumer.
//
// Parameters:
//   DEPTH      FIFO entries (power of two, 2..8)
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   rd_ld      one-cycle bit strobe from the reader
//   data_i     sampled SDA bit, valid with rd_ld
//   byte_mode  qualifies rd_ld (0 during ACK/NACK bit reads)
//   get_start  START / repeated START detected
//   get_stop   STOP detected
//   own_addr   7-bit slave address to match
//   m_data     FIFO head byte
//   m_first    FIFO head is the first byte after a START
//   m_valid    FIFO non-empty
//   m_ready    consumer accepts the head
//   addr_match one-cycle pulse when the address byte matches own_addr
//   rnw        R/W bit of the last address byte
//   overflow   sticky: a completed byte was dropped on a full FIFO
//   clr_ovf    clears overflow
module i2c_rx_byte #(
    parameter int DEPTH = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rd_ld,
    input  logic       data_i,
    input  logic       byte_mode,
    input  logic       get_start,
    input  logic       get_stop,
    input  logic [6:0] own_addr,
    output logic [7:0] m_data,
    output logic       m_first,
    output logic       m_valid,
    input  logic       m_ready,
    output logic       addr_match,
    output logic       rnw,
    output logic       overflow,
    input  logic       clr_ovf
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [7:0]    sh_r;
    logic [2:0]    cnt_r;
    logic          first_pend_r;
    logic [8:0]    mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [CW-1:0] count_r;
    logic          valid_r;
    logic          addr_match_r;
    logic          rnw_r;
    logic          overflow_r;

    logic [7:0]    sh_next_s;
    logic [2:0]    cnt_next_s;
    logic          first_next_s;
    logic [CW-1:0] count_next_s;
    logic          strobe_s;
    logic          done_s;
    logic [7:0]    byte_s;
    logic          pop_s;
    logic          full_s;
    logic          push_ok_s;
    logic          ovf_set_s;

    // START/STOP override any strobe in the same cycle.
    assign strobe_s  = rd_ld && byte_mode && !get_start && !get_stop;
    assign done_s    = strobe_s && (cnt_r == 3'd7);
    assign byte_s    = {sh_r[6:0], data_i};
    assign pop_s     = valid_r && m_ready;
    assign full_s    = (count_r == CW'(DEPTH));
    // A full FIFO still accepts a push when the head leaves at the same edge.
    assign push_ok_s = done_s && (!full_s || pop_s);
    assign ovf_set_s = done_s && full_s && !pop_s;

    // Next-state of the bit assembler; STOP beats START beats strobe.
    always_comb begin
        sh_next_s    = sh_r;
        cnt_next_s   = cnt_r;
        first_next_s = first_pend_r;
        if (get_stop) begin
            sh_next_s    = 8'h00;
            cnt_next_s   = 3'd0;
            first_next_s = 1'b0;
        end else if (get_start) begin
            sh_next_s    = 8'h00;
            cnt_next_s   = 3'd0;
            first_next_s = 1'b1;
        end else if (strobe_s) begin
            sh_next_s  = byte_s;
            cnt_next_s = cnt_r + 3'd1;
            if (cnt_r == 3'd7) begin
                first_next_s = 1'b0;
            end else begin
                first_next_s = first_pend_r;
            end
        end else begin
            sh_next_s    = sh_r;
            cnt_next_s   = cnt_r;
            first_next_s = first_pend_r;
        end
    end

    // Next FIFO occupancy; simultaneous push and pop leave it unchanged.
    always_comb begin
        count_next_s = count_r;
        if (push_ok_s && !pop_s) begin
            count_next_s = count_r + CW'(1);
        end else if (!push_ok_s && pop_s) begin
            count_next_s = count_r - CW'(1);
        end else begin
            count_next_s = count_r;
        end
    end

    // Bit assembler, address match and R/W registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            sh_r         <= 8'h00;
            cnt_r        <= 3'd0;
            first_pend_r <= 1'b0;
            addr_match_r <= 1'b0;
            rnw_r        <= 1'b0;
        end else begin
            sh_r         <= sh_next_s;
            cnt_r        <= cnt_next_s;
            first_pend_r <= first_next_s;
            addr_match_r <= done_s && first_pend_r && (byte_s[7:1] == own_addr);
            if (get_start && !get_stop) begin
                rnw_r <= 1'b0;
            end else if (done_s && first_pend_r) begin
                rnw_r <= byte_s[0];
            end else begin
                rnw_r <= rnw_r;
            end
        end
    end

    // FIFO storage, pointers, occupancy and sticky overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= 9'h000;
            end
            wr_ptr_r   <= '0;
            rd_ptr_r   <= '0;
            count_r    <= '0;
            valid_r    <= 1'b0;
            overflow_r <= 1'b0;
        end else begin
            if (push_ok_s) begin
                mem_r[wr_ptr_r] <= {first_pend_r, byte_s};
                wr_ptr_r        <= wr_ptr_r + AW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            count_r <= count_next_s;
            valid_r <= (count_next_s != '0);
            if (ovf_set_s) begin
                overflow_r <= 1'b1;
            end else if (clr_ovf) begin
                overflow_r <= 1'b0;
            end else begin
                overflow_r <= overflow_r;
            end
        end
    end

    // Head is read through the registered read pointer, so it only moves on a pop.
    assign m_data     = mem_r[rd_ptr_r][7:0];
    assign m_first    = mem_r[rd_ptr_r][8];
    assign m_valid    = valid_r;
    assign addr_match = addr_match_r;
    assign rnw        = rnw_r;
    assign overflow   = overflow_r;

endmodule
